// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding, bus width and timing defaults
// for the ADC sample sequencer.
package adc_pkg;

   localparam int ADC_WIDTH = 8;

   localparam int DEF_SAMPLE_PERIOD  = 50000;
   localparam int DEF_START_WIDTH    = 4;
   localparam int DEF_OE_CYCLES      = 3;
   localparam int DEF_TIMEOUT_CYCLES = 5000;
   localparam int DEF_VALID_HOLD     = 4;
   localparam int DEF_AVG_LOG2       = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_EOC,
      READ,
      OUTPUT
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: paces an 8-bit parallel ADC and hands results on.
// Define SAMPLE_AVG_EN to average 2**AVG_LOG2 captures per result.
module adc_sample_sequencer
   import adc_pkg::*;
#(
   parameter int SAMPLE_PERIOD  = DEF_SAMPLE_PERIOD,
   parameter int START_WIDTH    = DEF_START_WIDTH,
   parameter int OE_CYCLES      = DEF_OE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int VALID_HOLD     = DEF_VALID_HOLD,
   parameter int AVG_LOG2       = DEF_AVG_LOG2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 adc_eoc,
   input  logic [ADC_WIDTH-1:0] adc_data_in,
   output logic                 adc_start,
   output logic                 adc_oe,
   output logic [ADC_WIDTH-1:0] adc_data,
   output logic                 adc_data_valid,
   output logic                 busy,
   output logic                 timeout_err,
   output logic                 overrun_err,
   output logic [15:0]          sample_count
);

   if (SAMPLE_PERIOD < 64 || START_WIDTH < 1 || OE_CYCLES < 1 ||
       TIMEOUT_CYCLES < 1 || VALID_HOLD < 1 || AVG_LOG2 < 1) begin : g_bad_cfg
      $error("adc_sample_sequencer: parameter out of range");
   end

   localparam int PCW = $clog2(SAMPLE_PERIOD);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + START_WIDTH +
                               OE_CYCLES + VALID_HOLD);

   state_t               state, next;
   logic [PCW-1:0]       pcnt;
   logic [TW-1:0]        ccnt, lim;
   logic                 eoc_s, tick, last;
   logic                 timeout_hit, load, done_cap;
   logic [ADC_WIDTH-1:0] result;

   sync_2ff #(.WIDTH(1)) u_eoc_sync (
      .clk (clk),
      .rst (rst),
      .d   (adc_eoc),
      .q   (eoc_s)
   );

   always_ff @(posedge clk) begin
      if (rst || !enable)
         pcnt <= '0;
      else if (pcnt == PCW'(SAMPLE_PERIOD - 1))
         pcnt <= '0;
      else
         pcnt <= pcnt + 1'b1;
   end

   assign tick = enable && (pcnt == PCW'(SAMPLE_PERIOD - 1));

   always_comb begin
      unique case (state)
         START:    lim = TW'(START_WIDTH - 1);
         WAIT_EOC: lim = TW'(TIMEOUT_CYCLES - 1);
         READ:     lim = TW'(OE_CYCLES - 1);
         OUTPUT:   lim = TW'(VALID_HOLD - 1);
         default:  lim = '0;
      endcase
   end

   assign last        = (ccnt == lim);
   assign timeout_hit = (state == WAIT_EOC) && last && !eoc_s;
   assign load        = (state == READ) && last && done_cap;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE:     if (tick) next = START;
         START:    if (last) next = WAIT_EOC;
         WAIT_EOC: begin
            if (eoc_s)
               next = READ;
            else if (last)
               next = IDLE;
         end
         READ:     if (last) next = done_cap ? OUTPUT : IDLE;
         OUTPUT:   if (last) next = IDLE;
         default:  next = IDLE;
      endcase
   end

   always_comb begin
      adc_start      = (state == START);
      adc_oe         = (state == READ);
      adc_data_valid = (state == OUTPUT);
      busy           = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ccnt         <= '0;
         timeout_err  <= 1'b0;
         overrun_err  <= 1'b0;
         sample_count <= '0;
         adc_data     <= '0;
      end else begin
         ccnt <= (state == IDLE || next != state) ? '0 : ccnt + 1'b1;
         if (timeout_hit)
            timeout_err <= 1'b1;
         if (tick && state != IDLE)
            overrun_err <= 1'b1;
         if (state == OUTPUT && last)
            sample_count <= sample_count + 1'b1;
         if (load)
            adc_data <= result;
      end
   end

`ifdef SAMPLE_AVG_EN
   localparam int AW = ADC_WIDTH + AVG_LOG2;

   logic [AW-1:0]       acc, sum;
   logic [AVG_LOG2-1:0] ncap;

   assign sum      = acc + AW'(adc_data_in);
   assign done_cap = &ncap;
   assign result   = sum[AW-1:AVG_LOG2];

   // A timeout throws away any partial average.
   always_ff @(posedge clk) begin
      if (rst || timeout_hit || load) begin
         acc  <= '0;
         ncap <= '0;
      end else if (state == READ && last) begin
         acc  <= sum;
         ncap <= ncap + 1'b1;
      end
   end
`else
   assign done_cap = 1'b1;
   assign result   = adc_data_in;
`endif

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: scoreboard bench for adc_sample_sequencer.
// Instance a covers the nominal paths, instance b provokes overruns.
module tb_adc_sample_sequencer;

   localparam int P_A  = 100;
   localparam int P_B  = 64;
   localparam int TO_A = 50;
   localparam int VH   = 4;

   logic       clk = 1'b0;
   logic       rst_a, rst_b, en_a, en_b;
   logic       eoc_a = 1'b0, eoc_b = 1'b0;
   logic [7:0] adc_val;
   logic [7:0] data_a, data_b;
   logic       start_a, oe_a, valid_a, busy_a, terr_a, oerr_a;
   logic       start_b, oe_b, valid_b, busy_b, terr_b, oerr_b;
   logic [15:0] cnt_a, cnt_b;

   int         eoc_dly = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   logic [7:0] exp_q[$];
   int         exp_cnt = 0;
   int         exp_last = 0;
   int         acc_m = 0;
   int         n_m = 0;

   always #5 clk = ~clk;

   adc_sample_sequencer #(
      .SAMPLE_PERIOD  (P_A),
      .START_WIDTH    (4),
      .OE_CYCLES      (3),
      .TIMEOUT_CYCLES (TO_A),
      .VALID_HOLD     (VH),
      .AVG_LOG2       (2)
   ) dut_a (
      .clk            (clk),
      .rst            (rst_a),
      .enable         (en_a),
      .adc_eoc        (eoc_a),
      .adc_data_in    (adc_val),
      .adc_start      (start_a),
      .adc_oe         (oe_a),
      .adc_data       (data_a),
      .adc_data_valid (valid_a),
      .busy           (busy_a),
      .timeout_err    (terr_a),
      .overrun_err    (oerr_a),
      .sample_count   (cnt_a)
   );

   adc_sample_sequencer #(
      .SAMPLE_PERIOD  (P_B),
      .START_WIDTH    (4),
      .OE_CYCLES      (3),
      .TIMEOUT_CYCLES (5000),
      .VALID_HOLD     (VH),
      .AVG_LOG2       (2)
   ) dut_b (
      .clk            (clk),
      .rst            (rst_b),
      .enable         (en_b),
      .adc_eoc        (eoc_b),
      .adc_data_in    (8'hA5),
      .adc_start      (start_b),
      .adc_oe         (oe_b),
      .adc_data       (data_b),
      .adc_data_valid (valid_b),
      .busy           (busy_b),
      .timeout_err    (terr_b),
      .overrun_err    (oerr_b),
      .sample_count   (cnt_b)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic note_capture(input logic [7:0] v);
`ifdef SAMPLE_AVG_EN
      acc_m += int'(v);
      n_m++;
      if (n_m == 4) begin
         exp_q.push_back(8'(acc_m / 4));
         exp_last = acc_m / 4;
         exp_cnt++;
         acc_m = 0;
         n_m = 0;
      end
`else
      exp_q.push_back(v);
      exp_last = int'(v);
      exp_cnt++;
`endif
   endtask

   task automatic note_drop();
      acc_m = 0;
      n_m = 0;
   endtask

   // ADC models: EOC rises a fixed delay after a start edge, 0 = never.
   logic prev_a = 1'b0, prev_b = 1'b0;
   int   cd_a = 0, cd_b = 0;

   always @(posedge clk) begin
      prev_a <= start_a;
      if (start_a && !prev_a) begin
         eoc_a <= 1'b0;
         cd_a  <= eoc_dly;
      end else if (cd_a > 0) begin
         cd_a <= cd_a - 1;
         if (cd_a == 1) eoc_a <= 1'b1;
      end
   end

   always @(posedge clk) begin
      prev_b <= start_b;
      if (start_b && !prev_b) begin
         eoc_b <= 1'b0;
         cd_b  <= 80;
      end else if (cd_b > 0) begin
         cd_b <= cd_b - 1;
         if (cd_b == 1) eoc_b <= 1'b1;
      end
   end

   int         vlen = 0;
   logic [7:0] held = 8'h00;

   always @(negedge clk) begin
      if (valid_a) begin
         if (vlen == 0) begin
            if (exp_q.size() == 0)
               chk("a_unexpected_burst", exp_q.size(), 1);
            else
               chk("a_data", int'(data_a), int'(exp_q.pop_front()));
         end else begin
            chk("a_hold", int'(data_a), int'(held));
         end
         held <= data_a;
         vlen <= vlen + 1;
      end else if (vlen != 0) begin
         chk("a_valid_len", vlen, VH);
         vlen <= 0;
      end
   end

   logic vprev_b = 1'b0, oeprev_b = 1'b0;
   int   bursts_b = 0, convs_b = 0;

   always @(negedge clk) begin
      vprev_b  <= valid_b;
      oeprev_b <= oe_b;
      if (valid_b && !vprev_b) begin
         bursts_b <= bursts_b + 1;
         chk("b_data", int'(data_b), 'hA5);
      end
      if (oeprev_b && !oe_b)
         convs_b <= convs_b + 1;
   end

   task automatic one_sample(input logic [7:0] v, input int dly,
                             input bit drop, output int wc);
      bit seen;
      adc_val = v;
      eoc_dly = dly;
      wc = 0;
      seen = 1'b0;
      for (int i = 0; i < 3 * P_A && !seen; i++) begin
         @(negedge clk);
         seen = start_a;
      end
      chk("start_seen", int'(seen), 1);
      if (dly > 0) note_capture(v);
      else note_drop();
      for (int i = 0; i < 400 && busy_a; i++) begin
         @(negedge clk);
         if (busy_a && !start_a && !oe_a && !valid_a) wc++;
         if (drop && !start_a) en_a = 1'b0;
      end
      chk("idle_reached", int'(busy_a), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int  wc;
   int  n;
   bit  seen;

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      en_a = 1'b0;
      en_b = 1'b0;
      adc_val = 8'h00;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk("rst_start", int'(start_a), 0);
      chk("rst_oe", int'(oe_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_data", int'(data_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_terr", int'(terr_a), 0);
      chk("rst_oerr", int'(oerr_a), 0);
      chk("rst_count", int'(cnt_a), 0);

      en_a = 1'b1;
      en_b = 1'b1;
      one_sample(8'h80, 20, 1'b0, wc);
      chk("nom_count", int'(cnt_a), exp_cnt);
      chk("nom_terr", int'(terr_a), 0);
      chk("nom_oerr", int'(oerr_a), 0);

      one_sample(8'h33, 0, 1'b0, wc);
      chk("to_wait_cycles", wc, TO_A);
      chk("to_terr", int'(terr_a), 1);
      chk("to_count", int'(cnt_a), exp_cnt);

      one_sample(8'h41, 20, 1'b0, wc);
      chk("after_to_count", int'(cnt_a), exp_cnt);
      chk("terr_sticky", int'(terr_a), 1);

      one_sample(8'h5C, 20, 1'b1, wc);
      chk("drop_count", int'(cnt_a), exp_cnt);
      n = 0;
      repeat (3 * P_A) begin
         @(negedge clk);
         if (start_a) n++;
      end
      chk("drop_no_start", n, 0);

      adc_val = 8'h77;
      eoc_dly = 20;
      en_a = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3 * P_A && !seen; i++) begin
         @(negedge clk);
         seen = oe_a;
      end
      chk("read_seen", int'(seen), 1);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      chk("mid_rst_oe", int'(oe_a), 0);
      chk("mid_rst_valid", int'(valid_a), 0);
      chk("mid_rst_count", int'(cnt_a), 0);
      chk("mid_rst_busy", int'(busy_a), 0);
      chk("mid_rst_terr", int'(terr_a), 0);
      exp_cnt = 0;
      note_drop();

      one_sample(8'd10, 20, 1'b0, wc);
      one_sample(8'd20, 20, 1'b0, wc);
      one_sample(8'd30, 20, 1'b0, wc);
      one_sample(8'd41, 20, 1'b0, wc);
      chk("seq_count", int'(cnt_a), exp_cnt);
      chk("seq_data", int'(data_a), exp_last);
      chk("a_queue_drained", exp_q.size(), 0);
      chk("a_no_overrun", int'(oerr_a), 0);

      en_a = 1'b0;
      en_b = 1'b0;
      for (int i = 0; i < 300 && busy_b; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("b_idle", int'(busy_b), 0);
      chk("b_overrun", int'(oerr_b), 1);
      chk("b_no_timeout", int'(terr_b), 0);
      chk("b_convs_seen", int'(convs_b >= 4), 1);
`ifdef SAMPLE_AVG_EN
      chk("b_bursts", bursts_b, convs_b / 4);
`else
      chk("b_bursts", bursts_b, convs_b);
`endif
      chk("b_count", int'(cnt_b), bursts_b);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
